// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// write-port and control-bundle structs.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BUS_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam int NUM_OPS = 2;
    localparam int REG_W   = 5;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] wr;
    } wr_port_t;

    typedef struct packed {
        logic pc_stop;
        logic if_id_stop;
        logic if_id_flush;
        logic id_ex_stop;
        logic id_ex_flush;
        logic ex_mem_stop;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle; master is the datapath, slave is the controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [4:0]       id_rf_rr1, id_rf_rr2;
    logic             id_use_rs1, id_use_rs2;
    logic [4:0]       ex_rf_wr;
    logic             ex_rf_we, ex_is_load;
    logic [4:0]       ex_rf_rr1, ex_rf_rr2;
    logic [4:0]       mem_rf_wr, wb_rf_wr;
    logic             mem_rf_we, wb_rf_we;
    logic             ex_redirect, bus_busy;

    logic             pc_stop, if_id_stop, if_id_flush;
    logic             id_ex_stop, id_ex_flush, ex_mem_stop;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output id_rf_rr1, id_rf_rr2, id_use_rs1, id_use_rs2,
               ex_rf_wr, ex_rf_we, ex_is_load, ex_rf_rr1, ex_rf_rr2,
               mem_rf_wr, mem_rf_we, wb_rf_wr, wb_rf_we, ex_redirect, bus_busy,
        input  pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop,
               fwd_a_sel, fwd_b_sel, bus_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rf_rr1, id_rf_rr2, id_use_rs1, id_use_rs2,
               ex_rf_wr, ex_rf_we, ex_is_load, ex_rf_rr1, ex_rf_rr2,
               mem_rf_wr, mem_rf_we, wb_rf_wr, wb_rf_we, ex_redirect, bus_busy,
        output pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop,
               fwd_a_sel, fwd_b_sel, bus_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/haz_fwd_unit.sv
// Per-operand EX forwarding select; the younger EX_MEM result wins over MEM_WB.
module haz_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  wr_port_t         mem_wr,
    input  wr_port_t         wb_wr,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        // x0 is hardwired zero, so a zero source never takes a bypass
        if (src != '0) begin
            if (mem_wr.we && mem_wr.wr == src)     sel = FWD_EXMEM;
            else if (wb_wr.we && wb_wr.wr == src)  sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stalls, redirect flushes, bus-wait freeze, forwarding.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    hz_state_e  state, state_nx, ret_state, ret_nx, eff;
    logic [2:0] lu_cnt, lu_nx;
    logic [7:0] wait_cnt;
    logic       bus_err;
    logic       hazard;
    ctrl_t      ctl;

    assign hazard = hz.ex_is_load && hz.ex_rf_we && (hz.ex_rf_wr != '0) &&
                    ((hz.id_use_rs1 && hz.id_rf_rr1 == hz.ex_rf_wr) ||
                     (hz.id_use_rs2 && hz.id_rf_rr2 == hz.ex_rf_wr));

    // While frozen on the bus, behave as the state that was interrupted
    assign eff = (state == ST_BUS_WAIT) ? ret_state : state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            lu_cnt    <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            lu_cnt    <= lu_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ret_nx   = ret_state;
        lu_nx    = lu_cnt;
        if (hz.bus_busy) begin
            state_nx = ST_BUS_WAIT;
            ret_nx   = eff;
        end else if (hz.ex_redirect) begin
            state_nx = ST_RUN;
            lu_nx    = '0;
        end else if (eff == ST_LU_STALL) begin
            if (lu_cnt <= 3'd1) begin
                state_nx = ST_RUN;
                lu_nx    = '0;
            end else begin
                state_nx = ST_LU_STALL;
                lu_nx    = lu_cnt - 3'd1;
            end
        end else if (hazard && LOAD_LAT > 1) begin
            state_nx = ST_LU_STALL;
            lu_nx    = LU_INIT;
        end else begin
            state_nx = ST_RUN;
        end
    end

    always_comb begin
        ctl = '0;
        if (!rst) begin
            if (hz.bus_busy) begin
                ctl.pc_stop     = 1'b1;
                ctl.if_id_stop  = 1'b1;
                ctl.ex_mem_stop = 1'b1;
                ctl.id_ex_stop  = hazard;
            end else if (hz.ex_redirect) begin
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end else if (eff == ST_LU_STALL || hazard) begin
                ctl.pc_stop     = 1'b1;
                ctl.if_id_stop  = 1'b1;
                ctl.id_ex_stop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else if (hz.bus_busy) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (32'(wait_cnt) + 32'd1 >= 32'(BUS_TIMEOUT)) bus_err <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    logic [NUM_OPS-1:0][REG_W-1:0] ex_rr;
    logic [NUM_OPS-1:0][1:0]       fwd_sel;
    wr_port_t                      mem_p, wb_p;

    assign ex_rr = {hz.ex_rf_rr2, hz.ex_rf_rr1};
    assign mem_p = {hz.mem_rf_we, hz.mem_rf_wr};
    assign wb_p  = {hz.wb_rf_we, hz.wb_rf_wr};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        haz_fwd_unit u_fwd (
            .src    (ex_rr[i]),
            .mem_wr (mem_p),
            .wb_wr  (wb_p),
            .sel    (fwd_sel[i])
        );
    end

    assign hz.pc_stop     = ctl.pc_stop;
    assign hz.if_id_stop  = ctl.if_id_stop;
    assign hz.if_id_flush = ctl.if_id_flush;
    assign hz.id_ex_stop  = ctl.id_ex_stop;
    assign hz.id_ex_flush = ctl.id_ex_flush;
    assign hz.ex_mem_stop = ctl.ex_mem_stop;
    assign hz.fwd_a_sel   = rst ? FWD_RF : fwd_sel[0];
    assign hz.fwd_b_sel   = rst ? FWD_RF : fwd_sel[1];
    assign hz.bus_err     = bus_err;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl.pc_stop && stall_cnt != '1)     stall_cnt <= stall_cnt + CNT_W'(1);
            if (ctl.if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule
